// File: rtl/forward_scoreboard_pkg.sv
// Shared types and constants for the forwarding scoreboard.
package forward_scoreboard_pkg;

   // Result-latency classes: first position the value can be forwarded from is lat+1.
   localparam int LAT_ALU  = 1;
   localparam int LAT_LOAD = 2;
   localparam int LAT_MUL  = 3;

   // Forward-select encodings, named for the DEPTH=3 pipeline.
   localparam int FWD_RF  = 0;
   localparam int FWD_MEM = 2;
   localparam int FWD_WB  = 3;

   // Entry fields are sized for the widest supported configuration; narrower
   // register addresses and latency codes are stored zero-extended.
   localparam int AW_MAX = 8;
   localparam int LW_MAX = 3;

   typedef struct packed {
      logic              v;
      logic [AW_MAX-1:0] rd;
      logic [LW_MAX-1:0] lat;
   } sb_entry_t;

   // Latency 0 behaves as ALU; anything at or past the write-back slot is
   // capped so the result is always forwardable from some tracked stage.
   function automatic int clamp_lat(input int lat, input int depth);
      if (lat < 1)      return 1;
      if (lat >= depth) return depth - 1;
      return lat;
   endfunction

endpackage

// File: rtl/forward_scoreboard_if.sv
// ID-stage request / EX-stage forward-select bundle between the pipeline and the scoreboard.
interface forward_scoreboard_if #(
   parameter int NUM_SRC = 2,
   parameter int AW      = 5,
   parameter int LW      = 2,
   parameter int SW      = 2
);
   logic                  id_valid;
   logic [NUM_SRC*AW-1:0] id_raddr;
   logic [NUM_SRC-1:0]    id_src_use;
   logic [AW-1:0]         id_rd;
   logic                  id_regwrite;
   logic [LW-1:0]         id_lat;
   logic                  ext_stall;
   logic                  flush;
   logic                  hazard_stall;
   logic [NUM_SRC*SW-1:0] ex_fwd_sel;

   // Pipeline control side.
   modport master (
      output id_valid, id_raddr, id_src_use, id_rd, id_regwrite, id_lat, ext_stall, flush,
      input  hazard_stall, ex_fwd_sel
   );

   // Scoreboard side.
   modport slave (
      input  id_valid, id_raddr, id_src_use, id_rd, id_regwrite, id_lat, ext_stall, flush,
      output hazard_stall, ex_fwd_sel
   );
endinterface

// File: rtl/forward_scoreboard_fwd_src_match.sv
// Youngest-match and readiness check for a single source operand.
module fwd_src_match
   import forward_scoreboard_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int AW    = 5,
   parameter int SW    = 2
) (
   input  logic                  valid_i,
   input  logic                  use_i,
   input  logic [AW-1:0]         raddr_i,
   input  sb_entry_t [DEPTH-1:1] ent_i,
   output logic                  stall_o,
   output logic [SW-1:0]         sel_o
);

   // Scan from EX outward; the first hit is the youngest producer and hides older ones.
   always_comb begin
      logic found;
      found   = 1'b0;
      stall_o = 1'b0;
      sel_o   = '0;
      if (valid_i && use_i && (raddr_i != '0)) begin
         for (int p = 1; p < DEPTH; p++) begin
            if (!found && ent_i[p].v && (ent_i[p].rd == AW_MAX'(raddr_i))) begin
               found = 1'b1;
               if (p < int'(ent_i[p].lat)) stall_o = 1'b1;
               else                        sel_o   = SW'(p + 1);
            end
         end
      end
   end

endmodule

// File: rtl/forward_scoreboard.sv
// Forwarding/interlock scoreboard: tracks in-flight destinations, stalls ID on
// unready operands and registers per-source forward selects for EX.
module forward_scoreboard
   import forward_scoreboard_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int AW      = 5,
   parameter int DEPTH   = 3,
   parameter int LW      = 2,
   parameter int SW      = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   forward_scoreboard_if.slave sb
);

   // The write-back slot (position DEPTH) never matches, since the register
   // file is write-before-read, so only positions 1..DEPTH-1 need storage.
   sb_entry_t [DEPTH-1:1] e_q;
   sb_entry_t             new_ent;
   logic [NUM_SRC-1:0]    src_stall;
   logic [NUM_SRC*SW-1:0] sel_d;
   logic [NUM_SRC*SW-1:0] sel_q;
   logic                  hazard;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_match #(
         .DEPTH (DEPTH),
         .AW    (AW),
         .SW    (SW)
      ) u_match (
         .valid_i (sb.id_valid),
         .use_i   (sb.id_src_use[i]),
         .raddr_i (sb.id_raddr[i*AW +: AW]),
         .ent_i   (e_q),
         .stall_o (src_stall[i]),
         .sel_o   (sel_d[i*SW +: SW])
      );
   end

   // A flushed instruction is being killed, so it never holds the front end.
   assign hazard          = (|src_stall) & ~sb.flush;
   assign sb.hazard_stall = hazard;
   assign sb.ex_fwd_sel   = sel_q;

   // Entry the ID instruction would occupy in EX; x0 writes are not tracked.
   always_comb begin
      new_ent     = '0;
      new_ent.v   = sb.id_valid & sb.id_regwrite & (sb.id_rd != '0);
      new_ent.rd  = AW_MAX'(sb.id_rd);
      new_ent.lat = LW_MAX'(clamp_lat(int'(sb.id_lat), DEPTH));
   end

   // Advance the scoreboard and EX selects unless the whole pipe is frozen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_q   <= '0;
         sel_q <= '0;
      end else if (!sb.ext_stall) begin
         for (int p = DEPTH - 1; p >= 2; p--) e_q[p] <= e_q[p-1];
         if (sb.flush || hazard) begin
            e_q[1] <= '0;
            sel_q  <= '0;
         end else begin
            e_q[1] <= new_ent;
            sel_q  <= sel_d;
         end
      end
   end

endmodule
